// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single register-file write port: ALU (A) vs load unit (B),
// a one-cycle output register, and a busy scoreboard that raises oSTALL on stale operands.
module regfile_wb_arbiter #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int MAX_WAIT = 3
) (
  input  logic            iCLK,
  input  logic            iRST_N,
  input  logic            iA_VALID,
  output logic            oA_READY,
  input  logic [AW-1:0]   iA_RD,
  input  logic [XLEN-1:0] iA_DATA,
  input  logic            iB_VALID,
  output logic            oB_READY,
  input  logic [AW-1:0]   iB_RD,
  input  logic [XLEN-1:0] iB_DATA,
  input  logic            iISSUE_VALID,
  input  logic [AW-1:0]   iISSUE_RD,
  input  logic [AW-1:0]   iRS1,
  input  logic [AW-1:0]   iRS2,
  output logic            oSTALL,
  output logic            oRF_WE,
  output logic [AW-1:0]   oRF_RD,
  output logic [XLEN-1:0] oRF_WDATA
);

  localparam int CW = ($clog2(MAX_WAIT) > 0) ? $clog2(MAX_WAIT) : 1;

  typedef enum logic {PRI_A, PRI_B} arbState_t;

  arbState_t       state, stateNext;
  logic [CW-1:0]   starveCnt, starveCntNext;
  logic            grantA, grantB;
  logic [AW-1:0]   winRd;
  logic [XLEN-1:0] winData;
  logic [NREG-1:1] busy;
  logic [NREG-1:0] busyFull;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    oA_READY      = 1'b1;
    oB_READY      = ~iA_VALID;
    stateNext     = state;
    starveCntNext = '0;
    if (state == PRI_B) begin
      oA_READY  = ~iB_VALID;
      oB_READY  = 1'b1;
      // B is always granted here when valid, so PRI_B never lasts more than one cycle.
      stateNext = PRI_A;
    end else if (iB_VALID && !oB_READY) begin
      if (starveCnt == CW'(MAX_WAIT - 1)) begin
        stateNext = PRI_B;
      end else begin
        starveCntNext = starveCnt + 1'b1;
      end
    end
  end

  assign grantA  = iA_VALID & oA_READY;
  assign grantB  = iB_VALID & oB_READY;
  assign winRd   = grantB ? iB_RD : iA_RD;
  assign winData = grantB ? iB_DATA : iA_DATA;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state     <= PRI_A;
      starveCnt <= '0;
    end else begin
      state     <= stateNext;
      starveCnt <= starveCntNext;
    end
  end

  // x0 grants complete the handshake but never reach the register file.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oRF_WE    <= 1'b0;
      oRF_RD    <= '0;
      oRF_WDATA <= '0;
    end else begin
      oRF_WE <= (grantA | grantB) && (winRd != '0);
      if ((grantA | grantB) && (winRd != '0)) begin
        oRF_RD    <= winRd;
        oRF_WDATA <= winData;
      end
    end
  end

  // The scoreboard is only 31 flops, so it is reset like any other control state.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      busy <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (iISSUE_VALID && iISSUE_RD == AW'(i)) begin
          busy[i] <= 1'b1;
        end else if (oRF_WE && oRF_RD == AW'(i)) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

  assign busyFull = {busy, 1'b0};
  assign oSTALL   = ((iRS1 != '0) & busyFull[iRS1]) | ((iRS2 != '0) & busyFull[iRS2]);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: single writes, contention fairness, x0,
// scoreboard stall timing, simultaneous set/clear and asynchronous reset.
module tb_regfile_wb_arbiter;

  logic        iCLK = 1'b0;
  logic        iRST_N;
  logic        iA_VALID, iB_VALID, iISSUE_VALID;
  logic        oA_READY, oB_READY, oSTALL, oRF_WE;
  logic [4:0]  iA_RD, iB_RD, iISSUE_RD, iRS1, iRS2, oRF_RD;
  logic [31:0] iA_DATA, iB_DATA, oRF_WDATA;

  int nCompared = 0;
  int nMismatch = 0;

  regfile_wb_arbiter dut (
    .iCLK(iCLK), .iRST_N(iRST_N),
    .iA_VALID(iA_VALID), .oA_READY(oA_READY), .iA_RD(iA_RD), .iA_DATA(iA_DATA),
    .iB_VALID(iB_VALID), .oB_READY(oB_READY), .iB_RD(iB_RD), .iB_DATA(iB_DATA),
    .iISSUE_VALID(iISSUE_VALID), .iISSUE_RD(iISSUE_RD),
    .iRS1(iRS1), .iRS2(iRS2), .oSTALL(oSTALL),
    .oRF_WE(oRF_WE), .oRF_RD(oRF_RD), .oRF_WDATA(oRF_WDATA)
  );

  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatch++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    iRST_N = 1'b0;
    iA_VALID = 0; iB_VALID = 0; iISSUE_VALID = 0;
    iA_RD = 0; iB_RD = 0; iISSUE_RD = 0; iRS1 = 0; iRS2 = 0;
    iA_DATA = 0; iB_DATA = 0;
    #12;
    check("rst_we", 32'(oRF_WE), 0);
    check("rst_rd", 32'(oRF_RD), 0);
    check("rst_wdata", oRF_WDATA, 0);
    check("rst_stall", 32'(oSTALL), 0);
    @(negedge iCLK);
    iRST_N = 1'b1;
    tick();

    // T1: single ALU write
    iA_VALID = 1; iA_RD = 5; iA_DATA = 32'hDEADBEEF;
    #1;
    check("t1_a_ready", 32'(oA_READY), 1);
    check("t1_b_ready", 32'(oB_READY), 0);
    tick();
    iA_VALID = 0;
    check("t1_we", 32'(oRF_WE), 1);
    check("t1_rd", 32'(oRF_RD), 5);
    check("t1_wdata", oRF_WDATA, 32'hDEADBEEF);
    tick();
    check("t1_we_drop", 32'(oRF_WE), 0);
    check("t1_rd_hold", 32'(oRF_RD), 5);

    // T3: x0 write is accepted but never lands
    iA_VALID = 1; iA_RD = 0; iA_DATA = 32'h1234;
    #1;
    check("t3_a_ready", 32'(oA_READY), 1);
    tick();
    iA_VALID = 0;
    check("t3_we", 32'(oRF_WE), 0);
    iRS1 = 0; iRS2 = 0;
    #1;
    check("t3_stall", 32'(oSTALL), 0);
    tick();

    // T2: continuous contention, expected grants A,A,A,B repeating
    iA_VALID = 1; iA_RD = 1; iB_VALID = 1; iB_RD = 2;
    for (int k = 0; k < 8; k++) begin
      logic expB;
      expB = (k % 4 == 3);
      iA_DATA = 32'hA0 + k;
      iB_DATA = 32'hB0 + k;
      #1;
      check($sformatf("t2_a_ready_%0d", k), 32'(oA_READY), 32'(!expB));
      check($sformatf("t2_b_ready_%0d", k), 32'(oB_READY), 32'(expB));
      tick();
      check($sformatf("t2_we_%0d", k), 32'(oRF_WE), 1);
      check($sformatf("t2_rd_%0d", k), 32'(oRF_RD), expB ? 2 : 1);
      check($sformatf("t2_wdata_%0d", k), oRF_WDATA, expB ? 32'hB0 + k : 32'hA0 + k);
    end
    iA_VALID = 0; iB_VALID = 0;
    tick();

    // T4: scoreboard stall released the cycle after the write lands
    iISSUE_VALID = 1; iISSUE_RD = 7;
    tick();
    iISSUE_VALID = 0; iRS1 = 7;
    #1;
    check("t4_stall_issued", 32'(oSTALL), 1);
    iB_VALID = 1; iB_RD = 7; iB_DATA = 32'h77;
    #1;
    check("t4_b_ready", 32'(oB_READY), 1);
    tick();
    iB_VALID = 0;
    check("t4_we", 32'(oRF_WE), 1);
    check("t4_rd", 32'(oRF_RD), 7);
    check("t4_stall_we_cycle", 32'(oSTALL), 1);
    tick();
    check("t4_we_drop", 32'(oRF_WE), 0);
    check("t4_stall_clear", 32'(oSTALL), 0);

    // T5: set and clear of x9 on the same edge, set wins
    iRS1 = 0;
    iISSUE_VALID = 1; iISSUE_RD = 9;
    tick();
    iISSUE_VALID = 0;
    iA_VALID = 1; iA_RD = 9; iA_DATA = 32'h99;
    tick();
    iA_VALID = 0;
    check("t5_we", 32'(oRF_WE), 1);
    check("t5_rd", 32'(oRF_RD), 9);
    iISSUE_VALID = 1; iISSUE_RD = 9; iRS2 = 9;
    #1;
    check("t5_stall_pre", 32'(oSTALL), 1);
    tick();
    iISSUE_VALID = 0;
    check("t5_we_drop", 32'(oRF_WE), 0);
    check("t5_stall_kept", 32'(oSTALL), 1);

    // T6: asynchronous reset mid-cycle while in PRI_B
    iRS2 = 0;
    iISSUE_VALID = 1; iISSUE_RD = 3;
    tick();
    iISSUE_RD = 4;
    tick();
    iISSUE_VALID = 0; iRS1 = 3; iRS2 = 4;
    iA_VALID = 1; iA_RD = 1; iA_DATA = 32'h11;
    iB_VALID = 1; iB_RD = 4; iB_DATA = 32'h44;
    tick();
    tick();
    tick();
    check("t6_stall_pre", 32'(oSTALL), 1);
    check("t6_we_pre", 32'(oRF_WE), 1);
    check("t6_pri_b_a_ready", 32'(oA_READY), 0);
    check("t6_pri_b_b_ready", 32'(oB_READY), 1);
    #2;
    iRST_N = 1'b0;
    #1;
    check("t6_we_rst", 32'(oRF_WE), 0);
    check("t6_rd_rst", 32'(oRF_RD), 0);
    check("t6_stall_rst", 32'(oSTALL), 0);
    @(negedge iCLK);
    iRST_N = 1'b1;
    #1;
    check("t6_pri_a_a_ready", 32'(oA_READY), 1);
    check("t6_pri_a_b_ready", 32'(oB_READY), 0);
    check("t6_stall_post", 32'(oSTALL), 0);
    iA_VALID = 0; iB_VALID = 0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
